cipher_uart_tx: RTL and testbench

CIPHER_UART_TX -- requirements
Module: cipher_uart_tx

---
 rtl/cipher_tx_pkg.sv | 24 ++
 rtl/tx_byte_fifo.sv | 57 +++++
 rtl/cipher_uart_tx.sv | 146 ++++++++++++++
 tb/tb_cipher_uart_tx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_tx_pkg.sv
// rtl/cipher_tx_pkg.sv - shared FSM states and frame constants (CIPHER_UART_TX_PARITY_EN)
package cipher_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef CIPHER_UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_e;

  localparam int FRAME_BITS_NO_PARITY = 10;
  localparam int FRAME_BITS_PARITY    = 11;
`ifdef CIPHER_UART_TX_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_PARITY;
`else
  localparam int FRAME_BITS = FRAME_BITS_NO_PARITY;
`endif

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/tx_byte_fifo.sv
// rtl/tx_byte_fifo.sv - ciphertext byte FIFO; a push while full is accepted only alongside a pop
module tx_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 din,
  output logic [7:0]                 dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
  localparam logic [AW-1:0] PONE_C  = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          wr_ok;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];
  assign wr_ok = push && (!full || pop);

  always_comb begin
    count_d = count_q;
    case ({wr_ok, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= din;
  end

  // power-of-two depth lets the pointers wrap by natural overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PONE_C;
      if (pop)   rd_ptr_q <= rd_ptr_q + PONE_C;
    end
  end

endmodule

// File: rtl/cipher_uart_tx.sv
// rtl/cipher_uart_tx.sv - buffered UART transmitter for cipher output; CIPHER_UART_TX_PARITY_EN adds even parity
module cipher_uart_tx
  import cipher_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic       full,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       tx,
  output logic       busy,
  output logic       irq,
  input  logic       irq_ack
);
  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  state_e      state_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        tx_q, busy_q;
  logic        irq_q, irq_d;
  logic        ovf_q, ovf_d;
`ifdef CIPHER_UART_TX_PARITY_EN
  logic        par_q;
`endif

  logic          bit_end, pop, drop, to_idle;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

  tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_en),
    .pop   (pop),
    .din   (din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_end = (baud_q == BIT_LAST);
  // head byte leaves the FIFO on the same edge that loads the shifter
  assign pop     = !fifo_empty && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));
  assign drop    = wr_en && fifo_full && !pop;
  assign to_idle = (state_q == ST_STOP) && bit_end && (fifo_count == '0);

  always_comb begin
    irq_d = irq_q;
    if (irq_ack)      irq_d = 1'b0;
    else if (to_idle) irq_d = 1'b1;
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= IDLE_LEVEL;
      busy_q  <= 1'b0;
`ifdef CIPHER_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      baud_q <= (state_q == ST_IDLE || bit_end) ? '0 : baud_q + 16'd1;
      if (pop) begin
        state_q <= ST_START;
        shift_q <= fifo_dout;
        tx_q    <= 1'b0;
        busy_q  <= 1'b1;
`ifdef CIPHER_UART_TX_PARITY_EN
        par_q   <= ^fifo_dout;
`endif
      end else if (bit_end) begin
        case (state_q)
          ST_START: begin
            state_q <= ST_DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end
          ST_DATA: begin
            if (bit_q == 3'd7) begin
`ifdef CIPHER_UART_TX_PARITY_EN
              state_q <= ST_PARITY;
              tx_q    <= par_q;
`else
              state_q <= ST_STOP;
              tx_q    <= IDLE_LEVEL;
`endif
            end else begin
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end
`ifdef CIPHER_UART_TX_PARITY_EN
          ST_PARITY: begin
            state_q <= ST_STOP;
            tx_q    <= IDLE_LEVEL;
          end
`endif
          ST_STOP: begin
            state_q <= ST_IDLE;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign irq      = irq_q;
  assign overflow = ovf_q;
  assign full     = fifo_full;

endmodule

// File: tb/tb_cipher_uart_tx.sv
// tb/tb_cipher_uart_tx.sv - directed bench for cipher_uart_tx (CIPHER_UART_TX_PARITY_EN aware)
module tb_cipher_uart_tx;
  localparam int CPB = 4;
`ifdef CIPHER_UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset, wr_en, ovf_clr, irq_ack;
  logic [7:0] din;
  logic       full, overflow, tx, busy, irq;
  int         checks = 0;
  int         failures = 0;

  cipher_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .din      (din),
    .full     (full),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .tx       (tx),
    .busy     (busy),
    .irq      (irq),
    .irq_ack  (irq_ack)
  );

  always #5 clk = ~clk;

  function automatic logic exp_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
`ifdef CIPHER_UART_TX_PARITY_EN
    if (j == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en = 1'b1;
    din   = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic ack_irq();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_ack: irq=%b want 0", irq);
    end
  endtask

  task automatic check_frame(input logic [7:0] b);
    for (int i = 0; i < FB*CPB; i++) begin
      tick();
      checks++;
      if (tx !== exp_bit(b, i/CPB) || busy !== 1'b1 || irq !== 1'b0) begin
        failures++;
        $display("FAIL frame_%02h sample %0d: tx=%b busy=%b irq=%b want tx=%b busy=1 irq=0",
                 b, i, tx, busy, irq, exp_bit(b, i/CPB));
      end
    end
  endtask

  task automatic rx_byte(output logic [7:0] b);
    int n = 0;
    b = '0;
    while (tx !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (tx !== 1'b0) begin
      failures++;
      $display("FAIL rx_start: tx=%b want 0 within 300 cycles", tx);
      return;
    end
    repeat (CPB + CPB/2) tick();
    for (int k = 0; k < 8; k++) begin
      b[k] = tx;
      repeat (CPB) tick();
    end
`ifdef CIPHER_UART_TX_PARITY_EN
    checks++;
    if (tx !== ^b) begin
      failures++;
      $display("FAIL rx_parity: tx=%b want %b", tx, ^b);
    end
    repeat (CPB) tick();
`endif
    checks++;
    if (tx !== 1'b1) begin
      failures++;
      $display("FAIL rx_stop: tx=%b want 1", tx);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; wr_en = 1'b0; din = '0; ovf_clr = 1'b0; irq_ack = 1'b0;
    repeat (3) tick();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0 || overflow !== 1'b0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: tx=%b busy=%b full=%b ovf=%b irq=%b want 1 0 0 0 0",
               tx, busy, full, overflow, irq);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_one_frame(input logic [7:0] b);
    write_byte(b);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL latency_%02h: tx=%b busy=%b one cycle after write, want 1 0", b, tx, busy);
    end
    check_frame(b);
    tick();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || irq !== 1'b1) begin
      failures++;
      $display("FAIL end_%02h: tx=%b busy=%b irq=%b want 1 0 1", b, tx, busy, irq);
    end
  endtask

  task automatic test_single_frame();
    test_one_frame(8'hA5);
  endtask

  task automatic test_back_to_back();
    ack_irq();
    write_byte(8'h3C);
    fork
      begin
        check_frame(8'h3C);
        check_frame(8'hC3);
      end
      begin
        repeat (3) tick();
        write_byte(8'hC3);
      end
    join
    tick();
    checks++;
    if (busy !== 1'b0 || irq !== 1'b1 || tx !== 1'b1) begin
      failures++;
      $display("FAIL b2b_end: busy=%b irq=%b tx=%b want 0 1 1", busy, irq, tx);
    end
  endtask

  task automatic test_fifo_overflow();
    int n = 0;
    ack_irq();
    fork
      begin
        for (int k = 1; k <= 5; k++) begin
          wr_en = 1'b1;
          din   = 8'(k);
          tick();
        end
        wr_en = 1'b0;
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          failures++;
          $display("FAIL five_writes: full=%b ovf=%b want 1 0", full, overflow);
        end
        write_byte(8'h06);
        checks++;
        if (full !== 1'b1 || overflow !== 1'b1) begin
          failures++;
          $display("FAIL sixth_write: full=%b ovf=%b want 1 1", full, overflow);
        end
        ovf_clr = 1'b1;
        write_byte(8'h07);
        checks++;
        if (overflow !== 1'b1) begin
          failures++;
          $display("FAIL clr_vs_drop: ovf=%b want 1", overflow);
        end
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
          failures++;
          $display("FAIL ovf_clr: ovf=%b want 0", overflow);
        end
      end
      begin
        logic [7:0] got;
        for (int k = 1; k <= 5; k++) begin
          rx_byte(got);
          checks++;
          if (got !== 8'(k)) begin
            failures++;
            $display("FAIL fifo_order[%0d]: got %02h want %02h", k, got, 8'(k));
          end
        end
      end
    join
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0 || irq !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL drain_end: busy=%b irq=%b full=%b want 0 1 0", busy, irq, full);
    end
  endtask

  task automatic test_irq_ack_race();
    write_byte(8'h5A);
    repeat (FB*CPB) tick();
    checks++;
    if (busy !== 1'b1 || irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_sticky: busy=%b irq=%b want 1 1", busy, irq);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++;
    if (busy !== 1'b0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL ack_wins: busy=%b irq=%b want 0 0", busy, irq);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic bad = 1'b0;
    write_byte(8'h00);
    write_byte(8'h11);
    write_byte(8'h22);
    repeat (5) tick();
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_data: tx=%b busy=%b want 0 1", tx, busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0 || irq !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: tx=%b busy=%b full=%b irq=%b ovf=%b want 1 0 0 0 0",
               tx, busy, full, irq, overflow);
    end
    @(negedge clk);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL post_reset_idle: line left idle, residual frame seen (tx=%b busy=%b)", tx, busy);
    end
  endtask

`ifdef CIPHER_UART_TX_PARITY_EN
  task automatic test_parity();
    test_one_frame(8'h07);
    ack_irq();
    test_one_frame(8'h03);
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_fifo_overflow();
    test_irq_ack_race();
    test_reset_mid_frame();
`ifdef CIPHER_UART_TX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
